// File: rtl/dsp_mac_stream.sv
`timescale 1ns/1ps
// dsp_mac_stream
//   Streaming signed MAC slice with three pipeline stages:
//   pre-adder, then multiplier, then post-adder/accumulator.
//   Valid/ready handshakes on both sides. All stages advance together only when the output
//   register is empty or being drained. The op code travels with each beat.
//
//   Optional feature: define DSP_SAT_EN to saturate p on signed overflow.
//   Without it, p wraps in two's complement; ovf is reported in both builds.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready  input handshake; in_ready = !out_valid || out_ready
//   a [AW]             signed multiplier operand
//   b, d [BW]          signed pre-adder operands
//   c, pcin [PW]       signed post-adder operand, cascade input
//   op [5]             [0] pre-add enable, [1] pre-sub, [3:2] Z select, [4] post-sub
//   out_valid/out_ready output handshake
//   p, pcout [PW]      registered result (pcout mirrors p)
//   carryout, ovf      unsigned carry/borrow and signed overflow of the PW-bit post-add
module dsp_mac_stream #(
  parameter int unsigned AW = 18,
  parameter int unsigned BW = 18,
  parameter int unsigned PW = 48
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [AW-1:0] a,
  input  logic signed [BW-1:0] b,
  input  logic signed [BW-1:0] d,
  input  logic signed [PW-1:0] c,
  input  logic signed [PW-1:0] pcin,
  input  logic [4:0]           op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PW-1:0]        p,
  output logic [PW-1:0]        pcout,
  output logic                 carryout,
  output logic                 ovf
);

  localparam int unsigned MW = AW + BW;

  logic adv;

  // Stage 1: pre-adder result plus operands carried forward.
  // Only op[4:2] is needed past the pre-adder.
  logic                 s1_v_q;
  logic signed [BW-1:0] s1_x_q;
  logic signed [AW-1:0] s1_a_q;
  logic signed [PW-1:0] s1_c_q;
  logic signed [PW-1:0] s1_pcin_q;
  logic [2:0]           s1_op_q;
  logic signed [BW-1:0] pre_x;

  // Stage 2: product.
  logic                 s2_v_q;
  logic signed [MW-1:0] s2_m_q;
  logic signed [PW-1:0] s2_c_q;
  logic signed [PW-1:0] s2_pcin_q;
  logic [2:0]           s2_op_q;

  // Stage 3: result registers.
  logic                 out_valid_q;
  logic [PW-1:0]        p_q;
  logic                 carry_q;
  logic                 ovf_q;

  logic signed [PW-1:0] m_ext;
  logic signed [PW-1:0] z;
  logic [PW:0]          r;
  logic                 ovf_d;
  logic [PW-1:0]        p_d;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  // The pre-adder wraps at BW bits.
  assign pre_x = op[0] ? (op[1] ? d - b : d + b) : b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_x_q    <= '0;
      s1_a_q    <= '0;
      s1_c_q    <= '0;
      s1_pcin_q <= '0;
      s1_op_q   <= '0;
    end else if (adv) begin
      s1_v_q <= in_valid;
      if (in_valid) begin
        s1_x_q    <= pre_x;
        s1_a_q    <= a;
        s1_c_q    <= c;
        s1_pcin_q <= pcin;
        s1_op_q   <= op[4:2];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q    <= 1'b0;
      s2_m_q    <= '0;
      s2_c_q    <= '0;
      s2_pcin_q <= '0;
      s2_op_q   <= '0;
    end else if (adv) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_m_q    <= s1_x_q * s1_a_q;
        s2_c_q    <= s1_c_q;
        s2_pcin_q <= s1_pcin_q;
        s2_op_q   <= s1_op_q;
      end
    end
  end

  assign m_ext = PW'(s2_m_q);

  // Z source. Accumulate reads p_q as it stands when the beat enters stage 3.
  always_comb begin
    z = '0;
    unique case (s2_op_q[1:0])
      2'b00: z = '0;
      2'b01: z = s2_c_q;
      2'b10: z = signed'(p_q);
      2'b11: z = s2_pcin_q;
      default: z = '0;
    endcase
  end

  // PW+1-bit unsigned add/sub. The top bit is the carry, or the borrow when subtracting.
  assign r = s2_op_q[2] ? ({1'b0, z} - {1'b0, m_ext}) : ({1'b0, z} + {1'b0, m_ext});

  assign ovf_d = s2_op_q[2]
               ? ((z[PW-1] != m_ext[PW-1]) && (r[PW-1] != z[PW-1]))
               : ((z[PW-1] == m_ext[PW-1]) && (r[PW-1] != z[PW-1]));

`ifdef DSP_SAT_EN
  localparam logic [PW-1:0] PMax = {1'b0, {(PW-1){1'b1}}};
  localparam logic [PW-1:0] PMin = {1'b1, {(PW-1){1'b0}}};

  // On overflow the true result lies beyond the limit on Z's side.
  always_comb begin
    p_d = r[PW-1:0];
    if (ovf_d) p_d = z[PW-1] ? PMin : PMax;
  end
`else
  always_comb begin
    p_d = r[PW-1:0];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      p_q         <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (adv) begin
      out_valid_q <= s2_v_q;
      if (s2_v_q) begin
        p_q     <= p_d;
        carry_q <= r[PW];
        ovf_q   <= ovf_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign p         = p_q;
  assign pcout     = p_q;
  assign carryout  = carry_q;
  assign ovf       = ovf_q;

endmodule
